// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle between the issue logic, the shared ALU and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface alu_arbiter_if #(
  parameter int n    = 31,
  parameter int NREQ = 2
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*(n+1)-1:0]   req_a;
  logic [NREQ*(n+1)-1:0]   req_b;
  logic [NREQ*4-1:0]       req_S;
  logic [NREQ-1:0]         req_M;
  logic [NREQ-1:0]         req_cin;

  logic [n:0]              alu_a;
  logic [n:0]              alu_b;
  logic [3:0]              alu_S;
  logic                    alu_M;
  logic                    alu_cin;
  logic [n:0]              alu_do;
  logic [3:0]              alu_nvzc;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IW-1:0]           rsp_id;
  logic [n:0]              rsp_do;
  logic [3:0]              rsp_nvzc;

  modport slave (
    input  req_valid, req_a, req_b, req_S, req_M, req_cin, alu_do, alu_nvzc, rsp_ready,
    output req_ready, alu_a, alu_b, alu_S, alu_M, alu_cin, rsp_valid, rsp_id, rsp_do, rsp_nvzc
  );

  modport master (
    output req_valid, req_a, req_b, req_S, req_M, req_cin, alu_do, alu_nvzc, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_S, alu_M, alu_cin, rsp_valid, rsp_id, rsp_do, rsp_nvzc
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, result returned on a tagged valid/ready channel.
// Define ALU_ARB_PIPE_EN to drive the ALU combinationally from the winner and drop the EXEC cycle.
module alu_arbiter #(
  parameter int n    = 31,
  parameter int NREQ = 2
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int W  = n + 1;

`ifdef ALU_ARB_PIPE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
`endif

  state_t state, nxt;

  logic [NREQ-1:0][n:0] a_l, b_l;
  logic [NREQ-1:0][3:0] s_l;

  logic [IW-1:0]   last, win;
  logic            any, grant;
  logic [NREQ-1:0] rdy;
  int              cand;

  logic [n:0]      a_q, b_q;
  logic [3:0]      s_q;
  logic            m_q, cin_q;
  logic [IW-1:0]   rid_q;
  logic [n:0]      rdo_q;
  logic [3:0]      rnv_q;
`ifndef ALU_ARB_PIPE_EN
  logic [IW-1:0]   id_q;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign a_l[g] = bus.req_a[g*W +: W];
    assign b_l[g] = bus.req_b[g*W +: W];
    assign s_l[g] = bus.req_S[g*4 +: 4];
  end

  // Scan from farthest to nearest after last so the nearest valid index is the one left standing.
  always_comb begin
    any  = 1'b0;
    win  = '0;
    cand = 0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = (int'(last) + i) % NREQ;
      if (bus.req_valid[cand[IW-1:0]]) begin
        any = 1'b1;
        win = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (grant) begin
`ifdef ALU_ARB_PIPE_EN
        nxt = RESP;
`else
        nxt = EXEC;
`endif
      end
`ifndef ALU_ARB_PIPE_EN
      EXEC: nxt = RESP;
`endif
      RESP: if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Grant is masked while reset is held so nothing is accepted that reset would drop.
  always_comb begin
    grant = 1'b0;
    rdy   = '0;
    if (!rst && state == IDLE && any) begin
      grant = 1'b1;
      rdy   = NREQ'(1) << win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= IW'(NREQ - 1);
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      m_q   <= 1'b0;
      cin_q <= 1'b0;
      rid_q <= '0;
      rdo_q <= '0;
      rnv_q <= '0;
`ifndef ALU_ARB_PIPE_EN
      id_q  <= '0;
`endif
    end else begin
      if (grant) begin
        a_q   <= a_l[win];
        b_q   <= b_l[win];
        s_q   <= s_l[win];
        m_q   <= bus.req_M[win];
        cin_q <= bus.req_cin[win];
        last  <= win;
`ifdef ALU_ARB_PIPE_EN
        rdo_q <= bus.alu_do;
        rnv_q <= bus.alu_nvzc;
        rid_q <= win;
`else
        id_q  <= win;
`endif
      end
`ifndef ALU_ARB_PIPE_EN
      if (state == EXEC) begin
        rdo_q <= bus.alu_do;
        rnv_q <= bus.alu_nvzc;
        rid_q <= id_q;
      end
`endif
    end
  end

`ifdef ALU_ARB_PIPE_EN
  assign bus.alu_a   = grant ? a_l[win]          : a_q;
  assign bus.alu_b   = grant ? b_l[win]          : b_q;
  assign bus.alu_S   = grant ? s_l[win]          : s_q;
  assign bus.alu_M   = grant ? bus.req_M[win]    : m_q;
  assign bus.alu_cin = grant ? bus.req_cin[win]  : cin_q;
`else
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.alu_S   = s_q;
  assign bus.alu_M   = m_q;
  assign bus.alu_cin = cin_q;
`endif

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_do    = rdo_q;
  assign bus.rsp_nvzc  = rnv_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: randomized and directed traffic against a transaction-level model with a behavioural ALU.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
`ifdef ALU_ARB_PIPE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.n(31), .NREQ(NREQ)) bus ();
  alu_arbiter #(.n(31), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-in for the shared ALU: returns {N,V,Z,C,do}.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s, input logic m, input logic ci);
    logic [32:0] r;
    logic [31:0] d;
    logic v, c;
    r = '0; v = 1'b0; c = 1'b0; d = '0;
    if (m) begin
      case (s[1:0])
        2'd0:    d = a & b;
        2'd1:    d = a | b;
        2'd2:    d = a ^ b;
        default: d = ~a;
      endcase
    end else if (s == 4'b1001) begin
      r = {1'b0, a} + {1'b0, b} + 33'(ci);
      d = r[31:0]; c = r[32];
      v = (a[31] == b[31]) && (d[31] != a[31]);
    end else begin
      r = {1'b0, a} - {1'b0, b};
      d = r[31:0]; c = r[32];
      v = (a[31] != b[31]) && (d[31] != a[31]);
    end
    return {d[31], v, d == 32'd0, c, d};
  endfunction

  assign {bus.alu_nvzc, bus.alu_do} = alu_f(bus.alu_a, bus.alu_b, bus.alu_S, bus.alu_M, bus.alu_cin);

  int nchk = 0;
  int nerr = 0;
  int cnum = 0;
  int ord[$];
  int glog[$];
  logic pend, free, prst;
  int rstart, eid;
  logic [35:0] eres;
  logic o_vld;
  logic [1:0] o_id;
  logic [31:0] o_do;
  logic [3:0] o_nv;
  logic [NREQ-1:0] o_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cnum);
    end
  endtask

  task automatic setop(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic m, input logic c);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_S[i*4 +: 4] = s;
    bus.req_M[i]        = m;
    bus.req_cin[i]      = c;
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < NREQ; i++)
      setop(i, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 4'd9 : 4'($urandom),
            1'($urandom), 1'($urandom));
  endtask

  function automatic int gat(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  // One clock: check outputs at the negedge against the model, then advance the model to the next edge.
  task automatic cyc();
    int w;
    logic ev;
    logic [NREQ-1:0] er;
    @(negedge clk);
    o_vld = bus.rsp_valid; o_id = bus.rsp_id; o_do = bus.rsp_do;
    o_nv  = bus.rsp_nvzc;  o_rdy = bus.req_ready;
    if (rst) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      if (prst) begin
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        chk("rst_rsp_do",    64'(bus.rsp_do),    64'd0);
        chk("rst_rsp_nvzc",  64'(bus.rsp_nvzc),  64'd0);
      end
      pend = 1'b0; free = 1'b1;
      ord = '{0, 1, 2, 3};
    end else begin
      w = -1;
      if (free)
        foreach (ord[k]) if (w < 0 && bus.req_valid[ord[k]]) w = ord[k];
      er = (w >= 0) ? NREQ'(1) << w : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      ev = pend && (cnum >= rstart);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      if (ev) begin
        chk("rsp_id",   64'(bus.rsp_id),   64'(eid));
        chk("rsp_do",   64'(bus.rsp_do),   64'(eres[31:0]));
        chk("rsp_nvzc", 64'(bus.rsp_nvzc), 64'(eres[35:32]));
      end
      if (w >= 0) begin
        glog.push_back(w);
        while (ord[$] != w) ord.push_back(ord.pop_front());
        pend = 1'b1; free = 1'b0; rstart = cnum + LAT; eid = w;
        eres = alu_f(bus.req_a[w*W +: W], bus.req_b[w*W +: W], bus.req_S[w*4 +: 4],
                     bus.req_M[w], bus.req_cin[w]);
      end
      if (ev && bus.rsp_ready) begin
        pend = 1'b0; free = 1'b1;
      end
    end
    prst = rst;
    cnum++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s, n1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rnd_ops();
    pend = 1'b0; free = 1'b1; prst = 1'b0;
    ord = '{0, 1, 2, 3};

    rst = 1'b1; cyc(); cyc(); rst = 1'b0;

    // single op: all-ones plus one
    setop(0, 32'hFFFF_FFFF, 32'd1, 4'b1001, 1'b0, 1'b0);
    bus.req_valid = 4'b0001; cyc();
    bus.req_valid = '0;
    repeat (LAT) cyc();
    chk("single_vld",  64'(o_vld), 64'd1);
    chk("single_id",   64'(o_id),  64'd0);
    chk("single_do",   64'(o_do),  64'd0);
    chk("single_nvzc", 64'(o_nv),  64'h3);
    repeat (2) cyc();

    // reset while parked in RESP
    bus.req_valid = 4'b0001; bus.rsp_ready = 1'b0; cyc();
    bus.req_valid = '0; repeat (3) cyc();
    chk("stall_vld", 64'(o_vld), 64'd1);
    rst = 1'b1; bus.req_valid = 4'b0011; cyc(); cyc();
    chk("rst_vld", 64'(o_vld), 64'd0);
    rst = 1'b0; bus.rsp_ready = 1'b1; cyc();
    chk("rst_first_grant", 64'(o_rdy), 64'h1);

    // round-robin between 0 and 1
    s = glog.size() - 1;
    repeat (14) cyc();
    chk("rr_g0", 64'(gat(s)),     64'd0);
    chk("rr_g1", 64'(gat(s + 1)), 64'd1);
    chk("rr_g2", 64'(gat(s + 2)), 64'd0);
    chk("rr_g3", 64'(gat(s + 3)), 64'd1);

    // backpressure with a competing request pending
    bus.req_valid = '0; repeat (4) cyc();
    bus.req_valid = 4'b0001; cyc();
    bus.req_valid = 4'b0010; bus.rsp_ready = 1'b0;
    repeat (LAT + 5) cyc();
    chk("bp_hold_vld", 64'(o_vld), 64'd1);
    chk("bp_hold_rdy", 64'(o_rdy), 64'd0);
    bus.rsp_ready = 1'b1; cyc();
    chk("bp_hs_rdy", 64'(o_rdy), 64'd0);
    cyc();
    chk("bp_next_grant", 64'(o_rdy), 64'h2);
    bus.req_valid = '0; repeat (4) cyc();

    // wrap-around from last=3
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    s = glog.size();
    bus.req_valid = 4'b0101; repeat (8) cyc();
    chk("wrap_g0", 64'(gat(s)),     64'd0);
    chk("wrap_g1", 64'(gat(s + 1)), 64'd2);

    // request withdrawn while busy
    bus.req_valid = '0; repeat (4) cyc();
    s = glog.size();
    bus.req_valid = 4'b0001; cyc();
    bus.req_valid = 4'b0010; cyc();
    bus.req_valid = '0; repeat (6) cyc();
    n1 = 0;
    for (int k = s; k < glog.size(); k++) if (glog[k] == 1) n1++;
    chk("withdrawn_id1", 64'(n1), 64'd0);
    chk("withdrawn_cnt", 64'(glog.size() - s), 64'd1);

    // random traffic
    repeat (400) begin
      rnd_ops();
      bus.req_valid = NREQ'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    bus.req_valid = '0; bus.rsp_ready = 1'b1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit ALU datapath among NREQ requesters.
- Each requester presents an operation bundle: a, b, S, M, cin.
- The block grants one requester and registers its operands onto the ALU inputs. It then captures the ALU result and flags and returns them on a single valid/ready response channel tagged with the requester index.
- Sits between the instruction/issue logic and the shared ALU32 instance.

Parameters:
- n, 31, datapath MSB index (data width n+1).
- NREQ, 2, number of requesters (2..8).
- IW, $clog2(NREQ) (min 1), localparam, width of rsp_id.

Ports:
- clk in 1: single clock, all state on rising edge.
- rst in 1: synchronous, active-high reset.
- req_valid in NREQ: per-requester request valid.
- req_ready out NREQ: per-requester grant/accept, at most one bit set.
- req_a in NREQ*(n+1): packed operand A, requester i at [i*(n+1) +: n+1].
- req_b in NREQ*(n+1): packed operand B, same packing.
- req_S in NREQ*4: packed function select.
- req_M in NREQ: mode bit per requester.
- req_cin in NREQ: carry-in per requester.
- alu_a out n+1: to ALU a.
- alu_b out n+1: to ALU b.
- alu_S out 4: to ALU S.
- alu_M out 1: to ALU M.
- alu_cin out 1: to ALU cin.
- alu_do in n+1: from ALU do.
- alu_nvzc in 4: from ALU {N,V,Z,C}.
- rsp_valid out 1: result valid.
- rsp_ready in 1: consumer accepts result.
- rsp_id out IW: index of the requester that owns the result.
- rsp_do out n+1: captured result.
- rsp_nvzc out 4: captured {N,V,Z,C}.

Behaviour:
- Reset: state=IDLE, rr pointer last=NREQ-1 (so requester 0 has top priority first). All alu_* regs=0, rsp_valid=0, rsp_id=0, rsp_do=0, rsp_nvzc=0. Reset mid-operation discards the in-flight op with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search req_valid starting at index last+1 with wrap-around. The first set bit is the winner w.
  - req_ready[w]=1 combinationally, all other bits 0. No valid requests means req_ready=0 and state stays IDLE.
  - On the grant edge: the winner's a/b/S/M/cin are registered into alu_* regs, last<=w, id reg<=w, goto EXEC.
- EXEC:
  - The ALU settles from the registered inputs.
  - At the end of the cycle: rsp_do<=alu_do, rsp_nvzc<=alu_nvzc, rsp_id<=id, rsp_valid<=1, goto RESP.
- RESP:
  - rsp_valid=1. rsp_do/rsp_nvzc/rsp_id stay stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid<=0, goto IDLE.
  - rsp_ready held low stalls indefinitely.
- req_ready is 0 in EXEC and RESP. No new grant in the same cycle as the response handshake.
- Timing: grant at edge t, rsp_valid high from t+2. Minimum issue interval 3 cycles.
- alu_* outputs keep their last operands between operations (no toggling in IDLE).
- Requesters may drop req_valid without a grant. The arbiter evaluates only the current cycle's req_valid.
- Fairness: a continuously requesting requester is granted within NREQ grants.
- The block does no arithmetic. Flags pass through unmodified.

Optional Feature:
- Macro: ALU_ARB_PIPE_EN.
- Defined:
  - EXEC state is removed.
  - In IDLE, alu_* are driven combinationally from the winning requester's bundle (the previously registered values when there is no winner).
  - Result and flags are captured at the grant edge. rsp_valid is high from t+1; interval is 2 cycles.
- Undefined: registered 3-state behaviour as above.

Test Plan:
- Reset check: assert rst for 2 cycles while in RESP -> rsp_valid=0, req_ready=0 during reset, then req_ready=1 for requester 0 when both request.
- Single op: req0 a=32'hFFFF_FFFF, b=1, S=4'b1001, M=0, cin=0 with a real ALU32 -> rsp_valid at t+2 (t+1 with ALU_ARB_PIPE_EN), rsp_id=0, rsp_do=0, rsp_nvzc=4'b0011.
- Round-robin: NREQ=2, both valid continuously for 4 ops -> grant order 0,1,0,1, rsp_id sequence 0,1,0,1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_do and rsp_id stable, req_ready=0 throughout. Release -> next grant one cycle after the handshake.
- Wrap-around, NREQ=4: last=3, only req2 and req0 valid -> req0 granted, then req2.
- Withdrawn request: req1 valid for 1 cycle while busy, then dropped -> never granted, no response with rsp_id=1.
